// File: rtl/clock_gate_ctrl.sv
// Per-domain clock gating controller: idle-count gating, round-robin wake arbitration
// with at most one domain settling at a time, and a global force-on override.
module clock_gate_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DOMAINS-1:0] wake_req,
  input  logic [NUM_DOMAINS-1:0] busy,
  input  logic                   force_on,
  input  logic [CNT_W-1:0]       cfg_idle_thresh,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic [NUM_DOMAINS-1:0] ready,
  output logic [NUM_DOMAINS-1:0] gated
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } dom_state_e;

  localparam int               PTR_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_DOMAINS - 1);

  dom_state_e       state_q [NUM_DOMAINS];
  dom_state_e       state_d [NUM_DOMAINS];
  logic [CNT_W-1:0] idle_q  [NUM_DOMAINS];
  logic [CNT_W-1:0] idle_d  [NUM_DOMAINS];
  logic [3:0]       wake_cnt_q, wake_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic                   any_wake;
  logic [NUM_DOMAINS-1:0] eligible;
  logic                   hi_vld, lo_vld;
  logic [PTR_W-1:0]       hi_idx, lo_idx;
  logic                   grant_vld;
  logic [PTR_W-1:0]       grant_idx;

  // Round-robin pick: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    any_wake = 1'b0;
    eligible = '0;
    hi_vld   = 1'b0;
    lo_vld   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (state_q[i] == ST_WAKE) any_wake = 1'b1;
      eligible[i] = (state_q[i] == ST_GATED) && wake_req[i];
    end
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_vld = 1'b1;
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = PTR_W'(i);
        end
      end
    end
    grant_vld = !any_wake && lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    ptr_d      = ptr_q;
    wake_cnt_d = wake_cnt_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      unique case (state_q[i])
        ST_RUN: begin
          if (busy[i] || wake_req[i] || force_on) begin
            idle_d[i] = '0;
          end else begin
            if ((cfg_idle_thresh != '0) &&
                (({1'b0, idle_q[i]} + 1'b1) >= {1'b0, cfg_idle_thresh}))
              state_d[i] = ST_GATED;
            if (idle_q[i] != '1) idle_d[i] = idle_q[i] + 1'b1;
          end
        end
        ST_GATED: begin
          if (grant_vld && (grant_idx == PTR_W'(i))) state_d[i] = ST_WAKE;
        end
        ST_WAKE: begin
          // Only one domain can be waking, so a single shared settle counter is enough.
          if (wake_cnt_q == WAKE_LAST) begin
            state_d[i] = ST_RUN;
            idle_d[i]  = '0;
            wake_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        default: state_d[i] = ST_RUN;
      endcase
    end
    if (grant_vld) ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: these arrays are a handful of flops, not a RAM macro, so resetting them is cheap and required.
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= ST_RUN;
        idle_q[i]  <= '0;
      end
      wake_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
      end
      wake_cnt_q <= wake_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // force_on only overrides the gate enable; status outputs keep reflecting the FSM.
  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      clk_en[i] = (state_q[i] != ST_GATED) || force_on;
      ready[i]  = (state_q[i] == ST_RUN);
      gated[i]  = (state_q[i] == ST_GATED);
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the gating and wake rules.
module tb_clock_gate_ctrl;

  localparam int N    = 4;
  localparam int WC   = 2;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int M_RUN = 0, M_GATED = 1, M_WAKE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  wake_req = '0;
  logic [N-1:0]  busy = '0;
  logic          force_on = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic [N-1:0]  clk_en, ready, gated;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_gate_ctrl #(.NUM_DOMAINS(N), .WAKE_CYCLES(WC), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .wake_req        (wake_req),
    .busy            (busy),
    .force_on        (force_on),
    .cfg_idle_thresh (thresh),
    .clk_en          (clk_en),
    .ready           (ready),
    .gated           (gated)
  );

  // Behavioural model: mode per domain, idle counts, one waker with remaining cycles.
  int m_mode [N];
  int m_idle [N];
  int m_waker;
  int m_left;
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = M_RUN;
      m_idle[i] = 0;
    end
    m_waker = -1;
    m_left  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (m_waker < 0)
      for (int k = 0; k < N; k++) begin
        int d;
        d = (m_ptr + k) % N;
        if (g < 0 && m_mode[d] == M_GATED && wake_req[d]) g = d;
      end
    for (int i = 0; i < N; i++)
      if (m_mode[i] == M_RUN) begin
        if (busy[i] || wake_req[i] || force_on) m_idle[i] = 0;
        else begin
          if (thresh != 0 && m_idle[i] + 1 >= int'(thresh)) m_mode[i] = M_GATED;
          m_idle[i] = (m_idle[i] + 1 > MAXC) ? MAXC : m_idle[i] + 1;
        end
      end
    if (m_waker >= 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode[m_waker] = M_RUN;
        m_idle[m_waker] = 0;
        m_waker = -1;
      end
    end
    if (g >= 0) begin
      m_mode[g] = M_WAKE;
      m_waker   = g;
      m_left    = WC;
      m_ptr     = (g + 1) % N;
    end
  endtask

  function automatic logic [N-1:0] exp_clk_en();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_mode[i] != M_GATED) || force_on;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_mode[i] == M_RUN);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_gated();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_mode[i] == M_GATED);
    return r;
  endfunction

  // Advance n rising edges, stepping the model on each, and return on a falling edge.
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    wake_req = '0; busy = '0; force_on = 1'b0; thresh = 8'd4;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (clk_en !== 4'hF) begin errors++; $display("FAIL reset_clk_en got=%h exp=%h", clk_en, 4'hF); end
    checks++; if (ready !== 4'hF) begin errors++; $display("FAIL reset_ready got=%h exp=%h", ready, 4'hF); end
    checks++; if (gated !== 4'h0) begin errors++; $display("FAIL reset_gated got=%h exp=%h", gated, 4'h0); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready !== 4'hF || gated !== 4'h0 || clk_en !== 4'hF) begin
      errors++; $display("FAIL reset_release got en=%h rdy=%h gt=%h exp en=F rdy=F gt=0", clk_en, ready, gated);
    end
  endtask

  task automatic test_idle_gate();
    thresh = 8'd4; busy = '0; wake_req = '0;
    do_reset();
    tick(3); #1;
    checks++; if (gated[0] !== 1'b0) begin errors++; $display("FAIL idle_edge3 gated0 got=%b exp=0", gated[0]); end
    tick(1); #1;
    checks++; if (gated[0] !== 1'b1 || clk_en[0] !== 1'b0) begin
      errors++; $display("FAIL idle_edge4 got gt=%b en=%b exp gt=1 en=0", gated[0], clk_en[0]);
    end
    do_reset();
    tick(2);
    busy = 4'b0001;
    tick(1);
    busy = '0;
    tick(3); #1;
    checks++; if (gated[0] !== 1'b0) begin errors++; $display("FAIL busy_restart_edge6 gated0 got=%b exp=0", gated[0]); end
    tick(1); #1;
    checks++; if (gated[0] !== 1'b1) begin errors++; $display("FAIL busy_restart_edge7 gated0 got=%b exp=1", gated[0]); end
  endtask

  task automatic test_wake();
    thresh = 8'd1; busy = '0; wake_req = '0;
    do_reset();
    tick(1); #1;
    checks++; if (gated !== 4'hF) begin errors++; $display("FAIL wake_allgated got=%h exp=F", gated); end
    thresh = 8'd0;
    wake_req = 4'b0010;
    tick(1); #1;
    checks++; if (clk_en !== 4'b0010 || ready !== 4'b0000) begin
      errors++; $display("FAIL wake_edge1 got en=%h rdy=%h exp en=2 rdy=0", clk_en, ready);
    end
    tick(1); #1;
    checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL wake_edge2 ready1 got=%b exp=0", ready[1]); end
    tick(1); #1;
    checks++; if (ready !== 4'b0010 || gated !== 4'b1101) begin
      errors++; $display("FAIL wake_edge3 got rdy=%h gt=%h exp rdy=2 gt=D", ready, gated);
    end
    wake_req = '0;
  endtask

  task automatic test_back_to_back();
    int rdy_at [N];
    thresh = 8'd1; busy = '0; wake_req = '0;
    do_reset();
    tick(1);
    thresh = 8'd0;
    wake_req = 4'b1101;
    for (int i = 0; i < N; i++) rdy_at[i] = -1;
    for (int c = 1; c <= 12; c++) begin
      tick(1); #1;
      checks++; if ($countones(~ready & ~gated) > 1) begin
        errors++; $display("FAIL b2b_one_wake cycle=%0d waking=%h exp at most one", c, ~ready & ~gated);
      end
      for (int i = 0; i < N; i++) if (ready[i] && rdy_at[i] < 0) rdy_at[i] = c;
    end
    checks++; if (rdy_at[0] != 3) begin errors++; $display("FAIL b2b_ready0 got=%0d exp=3", rdy_at[0]); end
    checks++; if (rdy_at[2] != 6) begin errors++; $display("FAIL b2b_ready2 got=%0d exp=6", rdy_at[2]); end
    checks++; if (rdy_at[3] != 9) begin errors++; $display("FAIL b2b_ready3 got=%0d exp=9", rdy_at[3]); end
    checks++; if (rdy_at[1] != -1) begin errors++; $display("FAIL b2b_ready1 got=%0d exp=-1", rdy_at[1]); end
    wake_req = '0;
  endtask

  task automatic test_force_on();
    thresh = 8'd1; busy = '0; wake_req = '0;
    do_reset();
    tick(1);
    force_on = 1'b1;
    #1;
    checks++; if (clk_en !== 4'hF || gated !== 4'hF || ready !== 4'h0) begin
      errors++; $display("FAIL force_same_cycle got en=%h gt=%h rdy=%h exp en=F gt=F rdy=0", clk_en, gated, ready);
    end
    tick(3); #1;
    checks++; if (clk_en !== 4'hF || gated !== 4'hF) begin
      errors++; $display("FAIL force_hold got en=%h gt=%h exp en=F gt=F", clk_en, gated);
    end
    force_on = 1'b0;
    #1;
    checks++; if (clk_en !== 4'h0) begin errors++; $display("FAIL force_release got en=%h exp=0", clk_en); end
  endtask

  task automatic test_thresh_zero();
    thresh = 8'd0; busy = '0; wake_req = '0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      tick(1); #1;
      checks++; if (gated !== 4'h0) begin errors++; $display("FAIL thresh0 cycle=%0d got=%h exp=0", c, gated); end
    end
    thresh = 8'd5;
    #1;
    checks++; if (gated !== 4'h0) begin errors++; $display("FAIL thresh_lower_noedge got=%h exp=0", gated); end
    tick(1); #1;
    checks++; if (gated !== 4'hF) begin errors++; $display("FAIL thresh_lower_gate got=%h exp=F", gated); end
  endtask

  task automatic test_reset_mid_wake();
    thresh = 8'd1; busy = '0; wake_req = '0;
    do_reset();
    tick(1);
    thresh = 8'd0;
    wake_req = 4'b0100;
    tick(1); #1;
    checks++; if (clk_en !== 4'b0100 || ready !== 4'b0000) begin
      errors++; $display("FAIL midwake_pre got en=%h rdy=%h exp en=4 rdy=0", clk_en, ready);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (clk_en !== 4'hF || ready !== 4'hF || gated !== 4'h0) begin
      errors++; $display("FAIL midwake_async got en=%h rdy=%h gt=%h exp en=F rdy=F gt=0", clk_en, ready, gated);
    end
    @(negedge clk);
    rst = 1'b0;
    wake_req = '0;
    thresh = 8'd1;
    tick(1); #1;
    checks++; if (gated !== 4'hF) begin errors++; $display("FAIL midwake_regate got=%h exp=F", gated); end
    thresh = 8'd0;
    wake_req = 4'b1010;
    tick(1); #1;
    checks++; if (clk_en !== 4'b0010) begin errors++; $display("FAIL midwake_ptr0 got en=%h exp=2", clk_en); end
    wake_req = '0;
  endtask

  task automatic test_random();
    busy = '0; wake_req = '0; force_on = 1'b0; thresh = 8'd3;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        busy[i]     = ($urandom_range(0, 7) == 0);
        wake_req[i] = ($urandom_range(0, 5) == 0);
      end
      force_on = ($urandom_range(0, 15) == 0);
      if (c % 25 == 0) thresh = CW'($urandom_range(0, 6));
      #1;
      checks++; if (clk_en !== exp_clk_en()) begin errors++; $display("FAIL rand_clk_en cycle=%0d got=%h exp=%h", c, clk_en, exp_clk_en()); end
      checks++; if (ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cycle=%0d got=%h exp=%h", c, ready, exp_ready()); end
      checks++; if (gated !== exp_gated()) begin errors++; $display("FAIL rand_gated cycle=%0d got=%h exp=%h", c, gated, exp_gated()); end
      checks++; if ($countones(~ready & ~gated) > 1) begin
        errors++; $display("FAIL rand_one_wake cycle=%0d waking=%h exp at most one", c, ~ready & ~gated);
      end
      tick(1);
    end
    busy = '0; wake_req = '0; force_on = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_gate();
    test_wake();
    test_back_to_back();
    test_force_on();
    test_thresh_zero();
    test_reset_mid_wake();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
